// File: rtl/fifo_pdata_ctrl_if.sv
// rtl/fifo_pdata_ctrl_if.sv - byte push port and 32-bit word stream of the pixel-data FIFO
interface fifo_pdata_ctrl_if;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;

    // master: byte producer upstream and word consumer downstream
    modport master (
        output wr_en, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    // slave: the FIFO controller
    modport slave (
        input  wr_en, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/fifo_pdata_ctrl.sv
// rtl/fifo_pdata_ctrl.sv - pointer/level controller for the 8-bit-write 32-bit-read pixel FIFO memory
module fifo_pdata_ctrl #(
    parameter int AW       = 12,
    parameter int AF_LEVEL = 3840
) (
    input  logic                clk,
    input  logic                rst,
    fifo_pdata_ctrl_if.slave    bus,
    input  logic                i_flush,
    output logic                o_almost_full,
    output logic [AW:0]         o_level,
    output logic                o_ovf,
    output logic [AW-1:0]       o_mem_aw,
    output logic [7:0]          o_mem_dw,
    output logic                o_mem_cew,
    output logic [AW-3:0]       o_mem_ar,
    output logic                o_mem_cer,
    output logic                o_mem_rstr,
    input  logic [31:0]         i_mem_qr
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_WORD = (AW+1)'(4);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_LEVEL);

    typedef enum logic {S_IDLE, S_VALID} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_wptr;
    logic [AW-3:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            r_ovf;

    logic            w_full;
    logic            w_avail;
    logic            w_push;
    logic            w_fetch;
    logic            w_rd_valid;
    logic [AW:0]     w_level_nxt;

    // Full/available are taken from the registered level only, so a byte
    // written this cycle can first be fetched next cycle.
    assign w_full  = (r_level == LVL_FULL);
    assign w_avail = (r_level >= LVL_WORD);

    // rst is kept out of the flop data paths; the flops are held by the async
    // reset anyway, rst only masks the memory strobes below.
    assign w_push      = bus.wr_en & ~w_full & ~i_flush;
    assign w_level_nxt = r_level + (AW+1)'(w_push) - (w_fetch ? LVL_WORD : '0);

    // State register: async reset, flush returns to IDLE on the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (i_flush) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave VALID only when the held word is taken and no full word waits
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_avail) w_state_nxt = S_VALID;
            S_VALID: if (bus.rd_ready && !w_avail) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: fetch a word when the output stage is empty or being emptied
    always_comb begin
        w_fetch    = 1'b0;
        w_rd_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_fetch = w_avail & ~i_flush;
            end
            S_VALID: begin
                w_rd_valid = 1'b1;
                w_fetch    = bus.rd_ready & w_avail & ~i_flush;
            end
            default: begin
                w_fetch    = 1'b0;
                w_rd_valid = 1'b0;
            end
        endcase
    end

    // Pointers, fill level and sticky overflow; space is freed at fetch time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_fetch) begin
                r_rptr <= r_rptr + (AW-2)'(1);
            end
            r_level <= w_level_nxt;
            if (bus.wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.wr_ready  = ~w_full;
    assign bus.rd_valid  = w_rd_valid;
    assign bus.rd_data   = i_mem_qr;

    assign o_almost_full = (r_level >= LVL_AF);
    assign o_level       = r_level;
    assign o_ovf         = r_ovf;

    assign o_mem_aw      = r_wptr;
    assign o_mem_dw      = bus.wr_data;
    assign o_mem_cew     = w_push & ~rst;
    assign o_mem_ar      = r_rptr;
    assign o_mem_cer     = w_fetch & ~rst;
    assign o_mem_rstr    = rst | i_flush;
endmodule

// File: tb/tb_fifo_pdata_ctrl.sv
// tb/tb_fifo_pdata_ctrl.sv - scoreboard bench for fifo_pdata_ctrl with a behavioural EMB memory
module tb_fifo_pdata_ctrl;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            almost_full;
    logic [AW:0]     level;
    logic            ovf;
    logic [AW-1:0]   mem_aw;
    logic [7:0]      mem_dw;
    logic            mem_cew;
    logic [AW-3:0]   mem_ar;
    logic            mem_cer;
    logic            mem_rstr;
    logic [31:0]     mem_qr;

    logic [7:0]      mem [0:4095];
    logic [7:0]      sb [$];
    logic [31:0]     mon_word;
    int              n_chk   = 0;
    int              n_err   = 0;
    int              n_words = 0;
    int              words0;
    int              sent;

    fifo_pdata_ctrl_if bus();

    fifo_pdata_ctrl #(.AW(AW), .AF_LEVEL(3840)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .i_flush       (flush),
        .o_almost_full (almost_full),
        .o_level       (level),
        .o_ovf         (ovf),
        .o_mem_aw      (mem_aw),
        .o_mem_dw      (mem_dw),
        .o_mem_cew     (mem_cew),
        .o_mem_ar      (mem_ar),
        .o_mem_cer     (mem_cer),
        .o_mem_rstr    (mem_rstr),
        .i_mem_qr      (mem_qr)
    );

    always #5 clk = ~clk;

    // byte-write / word-read memory, one cycle read latency
    always @(posedge clk) begin
        if (mem_cew) mem[mem_aw] <= mem_dw;
        if (mem_rstr) mem_qr <= '0;
        else if (mem_cer) mem_qr <= {mem[{mem_ar, 2'b11}], mem[{mem_ar, 2'b10}],
                                     mem[{mem_ar, 2'b01}], mem[{mem_ar, 2'b00}]};
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // accepted words are compared against the oldest four pushed bytes
    always @(negedge clk) begin
        if (!rst && !flush && bus.rd_valid && bus.rd_ready) begin
            if (sb.size() < 4) begin
                chk("sb_underflow", sb.size(), 4);
            end else begin
                mon_word = {sb[3], sb[2], sb[1], sb[0]};
                for (int i = 0; i < 4; i++) void'(sb.pop_front());
                chk("rd_data", bus.rd_data, mon_word);
                n_words++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit acc);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (acc) sb.push_back(b);
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        cyc(); cyc();
        bus.wr_en = 1'b1;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_cew", mem_cew, 0);
        chk("rst_cer", mem_cer, 0);
        bus.wr_en = 1'b0;
        cyc();
        rst = 1'b0;

        // basic stream and latency
        bus.rd_ready = 1'b1;
        push(8'h11, 1); push(8'h22, 1); push(8'h33, 1); push(8'h44, 1);
        chk("t1_cer_n1", mem_cer, 1);
        chk("t1_valid_n1", bus.rd_valid, 0);
        push(8'h55, 1);
        chk("t1_valid_n2", bus.rd_valid, 1);
        chk("t1_level_n2", level, 1);
        push(8'h66, 1); push(8'h77, 1); push(8'h88, 1);
        repeat (4) cyc();
        chk("t1_words", n_words, 2);
        chk("t1_drained", sb.size(), 0);

        // write and fetch in the same cycle
        bus.rd_ready = 1'b0;
        push(8'hA0, 1); push(8'hA1, 1); push(8'hA2, 1); push(8'hA3, 1);
        chk("t4_level4", level, 4);
        chk("t4_cer", mem_cer, 1);
        push(8'hA4, 1);
        chk("t4_level1", level, 1);
        chk("t4_valid", bus.rd_valid, 1);
        push(8'hA5, 1); push(8'hA6, 1); push(8'hA7, 1);
        bus.rd_ready = 1'b1;
        repeat (4) cyc();
        chk("t4_drained", sb.size(), 0);

        // fill to full, almost_full threshold, overflow
        bus.rd_ready = 1'b0;
        for (int k = 1; k <= 4096; k++) begin
            push(8'(k), 1);
            if (k == 3843) chk("t2_af_below", almost_full, 0);
            if (k == 3844) chk("t2_af_at", almost_full, 1);
        end
        chk("t2_level4092", level, 4092);
        chk("t2_valid", bus.rd_valid, 1);
        chk("t2_ready_nf", bus.wr_ready, 1);
        for (int k = 4097; k <= 4100; k++) push(8'(k), 1);
        chk("t2_level_full", level, 4096);
        chk("t2_ready_full", bus.wr_ready, 0);
        chk("t2_ovf_pre", ovf, 0);
        push(8'hEE, 0);
        chk("t2_ovf", ovf, 1);
        chk("t2_level_hold", level, 4096);

        // drain to level 100, then flush with a write and pop in the flush cycle
        bus.rd_ready = 1'b1;
        for (int g = 0; g < 3000; g++) begin
            if (level == 100) break;
            cyc();
        end
        bus.rd_ready = 1'b0;
        chk("t5_level100", level, 100);
        chk("t5_valid_pre", bus.rd_valid, 1);
        chk("t5_ovf_pre", ovf, 1);
        flush = 1'b1; bus.rd_ready = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
        cyc();
        flush = 1'b0; bus.rd_ready = 1'b0; bus.wr_en = 1'b0;
        sb.delete();
        chk("t5_valid", bus.rd_valid, 0);
        chk("t5_level", level, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_wr_ready", bus.wr_ready, 1);
        chk("t5_af", almost_full, 0);
        chk("t5_aw", mem_aw, 0);
        chk("t5_ar", mem_ar, 0);

        // long stream with random backpressure, pointers wrap
        words0 = n_words;
        sent = 0;
        for (int c = 0; c < 40000; c++) begin
            if (sent >= 10000) break;
            bus.rd_ready = ($urandom_range(0, 3) != 0);
            if (sb.size() < 4000) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'(sent);
                sb.push_back(8'(sent));
                sent++;
            end else begin
                bus.wr_en = 1'b0;
            end
            cyc();
        end
        bus.wr_en = 1'b0; bus.rd_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        repeat (3) cyc();
        chk("t3_sent", sent, 10000);
        chk("t3_drained", sb.size(), 0);
        chk("t3_words", n_words - words0, 2500);

        // asynchronous reset mid-stream
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 13; k++) push(8'(8'h30 + k), 1);
        bus.wr_en = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_valid", bus.rd_valid, 0);
        chk("t6_wr_ready", bus.wr_ready, 1);
        chk("t6_level", level, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_cew", mem_cew, 0);
        chk("t6_cer", mem_cer, 0);
        chk("t6_rstr", mem_rstr, 1);
        bus.wr_en = 1'b0;
        cyc();
        rst = 1'b0;
        sb.delete();
        bus.rd_ready = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'hC1;
        sb.push_back(8'hC1);
        #1;
        chk("t6_aw0", mem_aw, 0);
        chk("t6_cew_on", mem_cew, 1);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        for (int k = 2; k <= 8; k++) push(8'(8'hC0 + k), 1);
        repeat (4) cyc();
        chk("t6_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
